// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue: PC sequencer feeding a DEPTH-entry {PC, instr} FIFO
// Optional same-cycle empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module ifetch_queue #(
    parameter int               DEPTH   = 4,
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] PC_INIT = '0,
    parameter logic [WIDTH-1:0] PC_INCR = WIDTH'(4)
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       IMemReq,
    output logic [WIDTH-1:0]           IMemAddr,
    input  logic                       IMemAck,
    input  logic [WIDTH-1:0]           IMemData,
    output logic                       InstrValid,
    output logic [WIDTH-1:0]           Instr,
    output logic [WIDTH-1:0]           InstrPC,
    input  logic                       InstrReady,
    input  logic                       Redirect,
    input  logic [WIDTH-1:0]           RedirectPC,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pc_q, pc_d;

    logic push, head_valid, bypass, bypass_take, wr_en, pop_mem;

    // IMemReq depends only on registered count, RST and Redirect, never on InstrReady.
    always_comb begin
        IMemReq    = !RST && (count_q < CW'(DEPTH)) && !Redirect;
        push       = IMemReq && IMemAck;
        head_valid = (count_q != '0);
`ifdef IFQ_BYPASS_EN
        bypass     = push && !head_valid;
`else
        bypass     = 1'b0;
`endif
        bypass_take = bypass && InstrReady;
        wr_en       = push && !bypass_take;
        pop_mem     = !RST && head_valid && InstrReady && !Redirect;
        InstrValid  = !RST && (head_valid || bypass);
        Instr       = bypass ? IMemData : instr_mem[rd_ptr_q];
        InstrPC     = bypass ? pc_q     : pc_mem[rd_ptr_q];
        IMemAddr    = pc_q;
        Count       = count_q;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        if (Redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = RedirectPC;
        end else begin
            if (push)
                pc_d = pc_q + PC_INCR;
            if (wr_en)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_mem)
                rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_en && !pop_mem)
                count_d = count_q + CW'(1);
            else if (!wr_en && pop_mem)
                count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= PC_INIT;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
        end
    end

    // Storage is not reset; validity is tracked solely by count_q.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= pc_q;
            instr_mem[wr_ptr_q] <= IMemData;
        end
    end

endmodule
